mac_accumulator: RTL
====================

# mac_accumulator

Sequential multiply-accumulate back end placed directly downstream of the 32x32 signed Wallace-tree multiplier (WTM32). It accepts one 64-bit two's-complement product per cycle over a valid/ready handshake. It sums the products of a frame into a wide accumulator, with optional saturation and a sticky overflow flag, and presents the final sum on a second valid/ready handshake. Typical use is dot products and FIR taps built on the combinational multiplier.

## Interface
- ACC_W, 72: accumulator and result width in bits; must be >= 64.
- CNT_W, 16: product-count width in bits.
- SAT, 1: 1 = saturate on overflow; 0 = wrap on overflow.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- clear  in  1  synchronous abort/clear of the current frame; highest priority.
- prod_valid  in  1  product is valid.
- prod_ready  out  1  block can take a product.
- product  in  64  signed product from WTM32.
- prod_last  in  1  qualifies the product as the final one of the frame.
- acc_valid  out  1  result is valid.
- acc_ready  in  1  consumer takes the result.
- acc_out  out  ACC_W  signed frame sum.
- acc_cnt  out  CNT_W  number of products in the frame.
- acc_ovf  out  1  sticky overflow flag for the frame.

## Operation
- State machine with two states:
  - ACC: prod_ready = ~clear. The block accepts products here.
  - OUT: prod_ready = 0 and acc_valid = 1. The block holds the result here.
- A product is accepted on any edge where prod_valid & prod_ready is true.
- Accept rule:
  - product is sign-extended to ACC_W+1 bits and added to acc (also sign-extended) in full precision.
  - Overflow exists when bits [ACC_W] and [ACC_W-1] of the sum differ.
  - When overflow occurs with SAT=1, acc is clamped to the ACC_W-bit maximum (positive overflow) or minimum (negative overflow).
  - When overflow occurs with SAT=0, acc keeps the low ACC_W bits of the sum.
  - ovf_sticky is set on any overflow.
  - cnt increments on each accept and saturates at 2^CNT_W-1.
- Accept with prod_last=1:
  - The updated sum, count and ovf are loaded into acc_out, acc_cnt and acc_ovf.
  - Internal acc, cnt and ovf_sticky are zeroed.
  - The state moves to OUT.
- OUT: when acc_ready=1, acc_valid drops on the next edge and the state moves to ACC. acc_out, acc_cnt and acc_ovf hold their values until the next frame is loaded.
- clear=1, in any state:
  - At the next edge, acc, cnt and ovf_sticky become 0, the state becomes ACC and acc_valid becomes 0.
  - Any product or result handshake in that cycle is discarded. prod_ready is already 0 combinationally.
  - acc_out, acc_cnt and acc_ovf are unchanged.
- No zero-length frames exist. The minimum frame is one product with prod_last=1.

## Timing
- Reset values: state ACC, acc 0, cnt 0, ovf_sticky 0, acc_valid 0, acc_out 0, acc_cnt 0, acc_ovf 0.
- prod_ready is 1 in the first cycle after reset release.
- Throughput is one product per cycle in ACC. There are no bubbles between products within a frame.
- Latency: if the last product is accepted at edge N, acc_valid is high in the cycle after edge N.
- Minimum gap between frames: one OUT cycle, when acc_ready is already high. The next frame's first product can be accepted at edge N+2.
- Outputs are registered; acc_valid must not depend combinationally on acc_ready.
- prod_ready is combinational from state and clear only. It must not depend on prod_valid.
- Asynchronous reset mid-frame or in OUT discards all state immediately. No partial result is emitted.
- product, prod_last and clear are sampled only at rising edges.

## Test plan
- Three products of -1 (0xFFFF_FFFF_FFFF_FFFF), prod_last on the third, acc_ready=1 -> acc_valid one cycle later, acc_out = 72'hFF_FFFF_FFFF_FFFF_FFFD, acc_cnt=3, acc_ovf=0.
- SAT=1, ACC_W=64: product 0x7FFF_FFFF_FFFF_FFFF, then product 1 with prod_last -> acc_out=0x7FFF_FFFF_FFFF_FFFF, acc_ovf=1. Same stimulus with SAT=0 -> acc_out=0x8000_0000_0000_0000, acc_ovf=1.
- Back-pressure: frame ends while acc_ready=0 for 5 cycles and prod_valid is held 1 -> prod_ready=0 throughout and acc_out stable. acc_ready=1 -> next frame's first product is accepted two edges later.
- Clear mid-frame: products 10 and 20 accepted, clear pulsed, then product 5 with prod_last -> acc_out=5, acc_cnt=1, acc_ovf=0.
- clear asserted in the same cycle as a prod_last product -> product dropped, no acc_valid. The following product 7 with last -> acc_out=7.
- rst_n pulsed low asynchronously mid-frame and again in OUT -> all outputs return to reset values immediately. A fresh 2-product frame (3, 4) yields acc_out=7, acc_cnt=2.

Source files
------------

// File: rtl/mac_accumulator.sv
// Multiply-accumulate back end for the WTM32 multiplier: sums a frame of signed
// 64-bit products into a wide accumulator and hands the total out on valid/ready.
module mac_accumulator #(
    parameter int ACC_W = 72,
    parameter int CNT_W = 16,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [63:0]      product,
    input  logic             prod_last,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] acc_cnt,
    output logic             acc_ovf
);

    localparam int EXT_W = ACC_W + 1 - 64;

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    state_t                    state, state_nxt;
    logic signed [ACC_W-1:0]   acc;
    logic        [CNT_W-1:0]   cnt;
    logic                      ovf_sticky;

    logic signed [ACC_W:0]     sum;
    logic signed [ACC_W-1:0]   acc_nxt;
    logic        [CNT_W-1:0]   cnt_nxt;
    logic                      ovf;
    logic                      accept;

    // Overflow shows as disagreement between the guard bit and the ACC_W-bit sign.
    function automatic logic signed [ACC_W-1:0] sat_sum(input logic signed [ACC_W:0] s);
        logic signed [ACC_W-1:0] r;
        r = s[ACC_W-1:0];
        if ((SAT != 0) && (s[ACC_W] != s[ACC_W-1])) begin
            r = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        return r;
    endfunction

    always_comb begin
        sum     = $signed({acc[ACC_W-1], acc}) + $signed({{EXT_W{product[63]}}, product});
        ovf     = sum[ACC_W] ^ sum[ACC_W-1];
        acc_nxt = sat_sum(sum);
        cnt_nxt = (&cnt) ? cnt : cnt + CNT_W'(1);
    end

    always_comb begin
        state_nxt  = state;
        prod_ready = 1'b0;
        acc_valid  = 1'b0;
        case (state)
            S_ACC: begin
                prod_ready = ~clear;
                if (prod_valid && !clear && prod_last) state_nxt = S_OUT;
            end
            S_OUT: begin
                acc_valid = 1'b1;
                if (acc_ready) state_nxt = S_ACC;
            end
            default: state_nxt = S_ACC;
        endcase
        if (clear) state_nxt = S_ACC;
    end

    assign accept = prod_valid & prod_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_ACC;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            acc_out    <= '0;
            acc_cnt    <= '0;
            acc_ovf    <= 1'b0;
        end else if (clear) begin
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
        end else if (accept) begin
            if (prod_last) begin
                // Result registers keep the frame total until the next frame closes.
                acc_out    <= acc_nxt;
                acc_cnt    <= cnt_nxt;
                acc_ovf    <= ovf_sticky | ovf;
                acc        <= '0;
                cnt        <= '0;
                ovf_sticky <= 1'b0;
            end else begin
                acc        <= acc_nxt;
                cnt        <= cnt_nxt;
                ovf_sticky <= ovf_sticky | ovf;
            end
        end
    end

endmodule
